// File: rtl/round_sequencer_if.sv
// Game-flow signal bundle between the VGA game datapath and the round sequencer.
// The sequencer uses the slave modport; the datapath (or a bench) drives through master.
interface round_sequencer_if;
    logic       Frame_Tick;
    logic       Fire;
    logic       Coin_Collect;
    logic       Player_Hit;
    logic       LevelSwitch_1;
    logic       LevelSwitch_0;
    logic       Game_Active;
    logic [1:0] Level;
    logic [2:0] Lives;
    logic [7:0] Coin_BCD;
    logic [7:0] Time_BCD;
    logic [1:0] State;
    logic       Win;

    modport master (
        output Frame_Tick, Fire, Coin_Collect, Player_Hit, LevelSwitch_1, LevelSwitch_0,
        input  Game_Active, Level, Lives, Coin_BCD, Time_BCD, State, Win
    );

    modport slave (
        input  Frame_Tick, Fire, Coin_Collect, Player_Hit, LevelSwitch_1, LevelSwitch_0,
        output Game_Active, Level, Lives, Coin_BCD, Time_BCD, State, Win
    );
endinterface

// File: rtl/round_sequencer.sv
// Round sequencer for the VGA game: attract/play/level-clear/game-over flow with
// BCD coin and time counters, lives and level, paced by a once-per-frame tick.
//
// state       | meaning
// IDLE        | attract mode, waiting for a Fire press
// PLAY        | round running, counters live, Game_Active high
// LEVEL_CLEAR | coin target reached, pause for CLEAR_FRAMES ticks
// GAME_OVER   | final values frozen for display, Fire returns to IDLE
module round_sequencer #(
    parameter int FRAMES_PER_SEC = 60,
    parameter int ROUND_SECONDS  = 60,
    parameter int START_LIVES    = 3,
    parameter int COIN_TARGET    = 10,
    parameter int CLEAR_FRAMES   = 120
) (
    input  logic           Master_Clock_In,
    input  logic           Reset_N_In,
    round_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        PLAY        = 2'b01,
        LEVEL_CLEAR = 2'b10,
        GAME_OVER   = 2'b11
    } state_t;

    localparam logic [7:0] FPS_LAST    = 8'(FRAMES_PER_SEC - 1);
    localparam logic [7:0] CLEAR_LAST  = 8'(CLEAR_FRAMES - 1);
    localparam logic [7:0] TIME_RELOAD = {4'(ROUND_SECONDS / 10), 4'(ROUND_SECONDS % 10)};
    localparam logic [7:0] COIN_GOAL   = {4'(COIN_TARGET / 10), 4'(COIN_TARGET % 10)};
    localparam logic [2:0] LIVES_INIT  = 3'(START_LIVES);

    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        if (v == 8'h99)
            return v;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v == 8'h00)
            return v;
        else if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    state_t     state_q;
    logic [1:0] level_q;
    logic [2:0] lives_q;
    logic [7:0] coin_q;
    logic [7:0] time_q;
    logic [7:0] frame_q;
    logic       win_q;
    logic       active_q;
    logic       fire_q;

    logic       fire_rise;
    logic       sec_done;
    logic [7:0] coin_play;
    logic [7:0] time_play;
    logic [2:0] lives_play;

    // Post-update PLAY values; transitions are judged on these, not the current registers.
    always_comb begin
        fire_rise  = bus.Fire & ~fire_q;
        sec_done   = bus.Frame_Tick && (frame_q == FPS_LAST);
        coin_play  = bus.Coin_Collect ? bcd_inc_sat(coin_q) : coin_q;
        time_play  = sec_done ? bcd_dec(time_q) : time_q;
        lives_play = (bus.Player_Hit && (lives_q != 3'd0)) ? lives_q - 3'd1 : lives_q;
    end

    always_ff @(posedge Master_Clock_In) begin
        if (!Reset_N_In) begin
            state_q  <= IDLE;
            level_q  <= 2'd0;
            lives_q  <= 3'd0;
            coin_q   <= 8'h00;
            time_q   <= 8'h00;
            frame_q  <= 8'd0;
            win_q    <= 1'b0;
            active_q <= 1'b0;
            fire_q   <= 1'b1;
        end else begin
            fire_q <= bus.Fire;
            case (state_q)
                IDLE: begin
                    if (fire_rise) begin
                        state_q  <= PLAY;
                        active_q <= 1'b1;
                        level_q  <= {bus.LevelSwitch_1, bus.LevelSwitch_0};
                        lives_q  <= LIVES_INIT;
                        coin_q   <= 8'h00;
                        time_q   <= TIME_RELOAD;
                        frame_q  <= 8'd0;
                        win_q    <= 1'b0;
                    end
                end

                PLAY: begin
                    coin_q  <= coin_play;
                    time_q  <= time_play;
                    lives_q <= lives_play;
                    if (sec_done)
                        frame_q <= 8'd0;
                    else if (bus.Frame_Tick)
                        frame_q <= frame_q + 8'd1;

                    if ((lives_play == 3'd0) || (time_play == 8'h00)) begin
                        state_q  <= GAME_OVER;
                        active_q <= 1'b0;
                        win_q    <= 1'b0;
                    end else if (coin_play == COIN_GOAL) begin
                        state_q  <= LEVEL_CLEAR;
                        active_q <= 1'b0;
                        frame_q  <= 8'd0;
                    end
                end

                LEVEL_CLEAR: begin
                    if (bus.Frame_Tick) begin
                        if (frame_q == CLEAR_LAST) begin
                            frame_q <= 8'd0;
                            if (level_q == 2'd3) begin
                                state_q <= GAME_OVER;
                                win_q   <= 1'b1;
                            end else begin
                                state_q  <= PLAY;
                                active_q <= 1'b1;
                                level_q  <= level_q + 2'd1;
                                coin_q   <= 8'h00;
                                time_q   <= TIME_RELOAD;
                            end
                        end else begin
                            frame_q <= frame_q + 8'd1;
                        end
                    end
                end

                GAME_OVER: begin
                    if (fire_rise)
                        state_q <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.State       = state_q;
    assign bus.Game_Active = active_q;
    assign bus.Level       = level_q;
    assign bus.Lives       = lives_q;
    assign bus.Coin_BCD    = coin_q;
    assign bus.Time_BCD    = time_q;
    assign bus.Win         = win_q;

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
Game-flow controller for the VGA game datapath. It sequences rounds (attract, play, level clear, game over) and owns the coin, timer, lives and level counters. It drives BCD values to the seven-segment interface and gates the drawing logic through Game_Active and Level. It runs in the 25 MHz pixel-clock domain and is paced by a once-per-frame tick.

Parameters:
FRAMES_PER_SEC, 60, Frame_Tick pulses per timer second (1..255)
ROUND_SECONDS, 60, round time reload value in seconds (1..99)
START_LIVES, 3, lives loaded at game start (1..7)
COIN_TARGET, 10, coins needed to clear a level (1..99)
CLEAR_FRAMES, 120, frames held in LEVEL_CLEAR (1..255)

Ports:
Master_Clock_In  in  1  25 MHz clock; all logic rising-edge
Reset_N_In  in  1  synchronous, active-low reset
Frame_Tick  in  1  single-cycle pulse, once per video frame
Fire  in  1  start/restart button, level, already debounced
Coin_Collect  in  1  single-cycle pulse, one coin picked up
Player_Hit  in  1  single-cycle pulse, player lost a life
LevelSwitch_1, LevelSwitch_0  in  1 each  start level {1,0} sampled on game start
Game_Active  out  1  high only in PLAY
Level  out  2  current level 0..3
Lives  out  3  remaining lives
Coin_BCD  out  8  coins this level, [7:4] tens, [3:0] units
Time_BCD  out  8  seconds remaining, [7:4] tens, [3:0] units
State  out  2  00 IDLE, 01 PLAY, 10 LEVEL_CLEAR, 11 GAME_OVER
Win  out  1  high in GAME_OVER only if the final level was cleared

Behaviour:
- Reset (Reset_N_In=0 at clock edge): State=IDLE, Game_Active=0, Level=0, Lives=0, Coin_BCD=00, Time_BCD=00, Win=0, frame counter=0, Fire history register=1. Reset asserted mid-round aborts the round immediately with no residual pulses.
- Fire edge detection: fire_rise = Fire & ~Fire_q. Because Fire_q resets to 1, a Fire held through reset release does not start a game.
- All outputs are registered and reflect events one cycle after the input pulse.
- IDLE: on fire_rise, go to PLAY. Load Level={LevelSwitch_1,LevelSwitch_0}, Lives=START_LIVES, Coin_BCD=00, Time_BCD=BCD(ROUND_SECONDS), frame counter=0, Win=0.
- PLAY:
  - Frame_Tick increments the frame counter.
  - When the counter reaches FRAMES_PER_SEC-1 together with a tick, the counter clears and Time_BCD decrements by one in BCD. A units digit of 0 becomes 9 and the tens digit decrements.
  - Coin_Collect increments Coin_BCD in BCD (09 becomes 10). It saturates at 99.
  - Player_Hit decrements Lives. Lives never goes below 0.
  - Transitions are evaluated on the post-update values in the same cycle:
    - Lives==0 or Time_BCD==00 -> GAME_OVER with Win=0. This has priority.
    - Otherwise Coin_BCD==BCD(COIN_TARGET) -> LEVEL_CLEAR.
  - If a coin, a hit and a second boundary arrive in the same cycle, all three counters update, then the priority rule above applies.
  - Fire is ignored.
- LEVEL_CLEAR:
  - Game_Active=0. Counters are frozen and inputs are ignored except Frame_Tick.
  - The state holds for CLEAR_FRAMES ticks using the frame counter, which is cleared on entry.
  - On expiry with Level<3: Level+1, Coin_BCD=00, Time_BCD reloaded, frame counter=0, then -> PLAY. Lives is kept.
  - On expiry with Level==3: Win=1, then -> GAME_OVER. Coin_BCD and Time_BCD are kept.
- GAME_OVER:
  - All counters are frozen for display.
  - fire_rise -> IDLE. Coin_BCD, Time_BCD, Lives, Level and Win hold their values until the next game start.
- The Level switches are sampled only on the IDLE->PLAY transition. Changes at any other time have no effect.

Test Plan:
- Reset with Fire held high, then release reset with Fire still high -> State stays 00. Drop Fire and raise it -> State=01 next cycle, Lives=3, Time_BCD=8'h60, Coin_BCD=00.
- PLAY with FRAMES_PER_SEC=2: 2 Frame_Ticks -> Time_BCD 60 to 59. 18 more -> 50. Continue to 00 -> State=11, Win=0, Game_Active=0.
- 10 Coin_Collect pulses -> Coin_BCD steps 09 to 10, then State=10. After 120 ticks -> State=01, Level+1, Coin_BCD=00, Time_BCD=60, Lives unchanged.
- Lives=1: Player_Hit and the 10th Coin_Collect in the same cycle -> State=11, Win=0, Coin_BCD=10, Lives=0.
- Start with switches=11, clear the level -> after CLEAR_FRAMES, State=11, Win=1. fire_rise -> State=00 with values held. Next fire_rise reloads all counters.
- Assert Reset_N_In low mid-PLAY for one cycle -> all outputs at reset values next cycle. A Coin_Collect in the reset cycle is discarded.
